spi_sram_responder: RTL

SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

---
 rtl/spi_sram_responder_pkg.sv | 7 +
 rtl/spi_sram_mem.sv | 16 +
 rtl/spi_sram_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_sram_responder_pkg.sv
// spi_sram_responder_pkg: opcodes, address field width and FSM states shared with the SPI initiator
package spi_sram_responder_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int ADDR_BITS = 24;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;
endpackage

// File: rtl/spi_sram_mem.sv
// spi_sram_mem: single-port byte memory with synchronous 1-cycle read and byte write enable
module spi_sram_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/spi_sram_responder.sv
// spi_sram_responder: SPI mode-0 target exposing a byte SRAM through 0x03 read / 0x02 write commands
module spi_sram_responder
  import spi_sram_responder_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic busy_o
);
  localparam int SW = MEM_AW > 8 ? MEM_AW : 8;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_cs_s, r_mosi_s;
  logic r_sclk_d, r_cs_d, r_busy, r_oe, r_miso, r_rd, r_fetch, r_load, r_we;
  logic [4:0] r_cnt;
  logic [SW-2:0] r_shift;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0] r_tx, r_wdata, w_rdata;
  logic w_sclk, w_cs, w_mosi, w_rise, w_fall, w_cs_rise, w_cs_fall, w_last;
  logic [SW-1:0] w_shift_in;
  state_t r_state, w_next;
  assign w_sclk = r_sclk_s[SYNC_STAGES-1];
  assign w_cs = r_cs_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;
  assign w_cs_rise = w_cs & ~r_cs_d;
  assign w_cs_fall = ~w_cs & r_cs_d;
  assign w_shift_in = {r_shift, w_mosi};
  assign w_last = (r_state == ADDR) ? (r_cnt == 5'(ADDR_BITS - 1)) : (r_cnt == 5'd7);
  assign miso_o = r_miso & r_oe;
  assign miso_oe_o = r_oe;
  assign busy_o = r_busy;
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) w_next = IDLE;
    else case (r_state)
      IDLE: w_next = w_cs_fall ? CMD : IDLE;
      CMD: if (w_rise && w_last)
        w_next = (w_shift_in[7:0] == CMD_READ || w_shift_in[7:0] == CMD_WRITE) ? ADDR : IGNORE;
      ADDR: if (w_rise && w_last) w_next = r_rd ? READ : WRITE;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_s <= '0;
      r_cs_s <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d <= 1'b1;
      {r_busy, r_oe, r_miso, r_rd, r_fetch, r_load, r_we} <= '0;
      r_cnt <= '0;
      r_shift <= '0;
      r_addr <= '0;
      r_tx <= '0;
      r_wdata <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk_i};
      r_cs_s <= {r_cs_s[SYNC_STAGES-2:0], cs_i};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi_i};
      r_sclk_d <= w_sclk;
      r_cs_d <= w_cs;
      r_busy <= ~w_cs;
      r_fetch <= 1'b0;
      r_load <= r_fetch;
      r_we <= 1'b0;
      if (r_load) r_tx <= w_rdata;
      if (r_we) r_addr <= r_addr + MEM_AW'(1);
      if (w_cs_rise) begin
        r_oe <= 1'b0;
        r_miso <= 1'b0;
      end else case (r_state)
        IDLE: if (w_cs_fall) begin
          r_cnt <= '0;
          r_shift <= '0;
        end
        CMD, ADDR: if (w_rise) begin
          r_shift <= w_shift_in[SW-2:0];
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (r_state == CMD && w_last) r_rd <= (w_shift_in[7:0] == CMD_READ);
          if (r_state == ADDR && w_last) begin
            r_addr <= w_shift_in[MEM_AW-1:0];
            r_fetch <= r_rd;
          end
        end
        // Fetch of the next byte starts as soon as bit 0 goes out, well ahead of the next falling edge
        READ: if (w_fall) begin
          r_miso <= r_tx[7];
          r_oe <= 1'b1;
          r_tx <= {r_tx[6:0], 1'b0};
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (w_last) begin
            r_addr <= r_addr + MEM_AW'(1);
            r_fetch <= 1'b1;
          end
        end
        WRITE: if (w_rise) begin
          r_shift <= w_shift_in[SW-2:0];
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (w_last) begin
            r_we <= 1'b1;
            r_wdata <= w_shift_in[7:0];
          end
        end
        default: ;
      endcase
    end
  end
  spi_sram_mem #(.AW(MEM_AW)) u_mem (
    .clk(clk),
    .i_we(r_we),
    .i_addr(r_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );
endmodule
